// File: rtl/sbox_share_seq.sv
// Masked S-box sequencer: issues shared bytes to an external pipelined S-box,
// tracks tokens through a fixed-latency delay line, recombines the output shares
// and buffers the results in a first-word-fall-through FIFO.
module sbox_share_seq #(
  parameter int unsigned SHARES     = 2,
  parameter int unsigned LANES      = 1,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  input  logic                          StartxSI,
  input  logic [7:0]                    BasexDI,
  input  logic [8:0]                    BeatsxDI,
  input  logic [8*(SHARES-1)*LANES-1:0] RandxDI,
  input  logic                          RandValidxSI,
  output logic [8*SHARES*LANES-1:0]     _XxDO,
  input  logic [8*SHARES*LANES-1:0]     _QxDI,
  output logic [8*LANES-1:0]            ResxDO,
  output logic [7:0]                    IdxxDO,
  output logic                          ResValidxSO,
  input  logic                          ResReadyxSI,
  output logic                          BusyxSO,
  output logic                          DonexSO
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW = 8 * LANES + 8;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [7:0]        r_cur;
  logic [8:0]        r_rem;
  logic [CntW-1:0]   r_inflight;
  logic [CntW-1:0]   r_count;
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic              r_vld [LATENCY];
  logic [7:0]        r_idx [LATENCY];
  logic [EntW-1:0]   r_mem [FIFO_DEPTH];

  logic              w_start, w_issue, w_emerge, w_push, w_pop;
  logic [SumW-1:0]   w_occ;
  logic [8*LANES-1:0] w_res;
  logic [7:0]        w_acc, w_racc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FIFO_DEPTH - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign w_start  = (r_state == StIdle) && StartxSI;
  assign w_occ    = SumW'(r_inflight) + SumW'(r_count);
  // Tokens in flight are counted against the FIFO so an emerging result always has a slot.
  assign w_issue  = (r_state == StRun) && (r_rem != 9'd0) && RandValidxSI &&
                    (w_occ < SumW'(FIFO_DEPTH));
  assign w_emerge = r_vld[LATENCY-1];
  assign w_push   = w_emerge;
  assign w_pop    = (r_count != '0) && ResReadyxSI;

  // State register
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_state_nxt = r_state;
    BusyxSO     = 1'b0;
    DonexSO     = 1'b0;
    case (r_state)
      StIdle: if (StartxSI) w_state_nxt = StRun;
      StRun: begin
        BusyxSO = 1'b1;
        if (r_rem == 9'd0) w_state_nxt = StDrain;
      end
      StDrain: begin
        BusyxSO = 1'b1;
        if ((r_inflight == '0) && (r_count == '0)) w_state_nxt = StDone;
      end
      StDone: begin
        DonexSO     = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Current byte and remaining-beat counter; zero beats means a full 256-beat run
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_cur <= '0;
      r_rem <= '0;
    end else if (w_start) begin
      r_cur <= BasexDI;
      r_rem <= (BeatsxDI == 9'd0) ? 9'd256 : BeatsxDI;
    end else if (w_issue) begin
      r_cur <= r_cur + 8'(LANES);
      r_rem <= r_rem - 9'd1;
    end
  end

  // Share generation: share 0 is formed combinationally so x itself is never stored
  always_comb begin
    _XxDO = '0;
    w_acc = '0;
    if (w_issue) begin
      for (int l = 0; l < int'(LANES); l++) begin
        w_acc = r_cur + 8'(l);
        for (int s = 1; s < int'(SHARES); s++) begin
          _XxDO[(l*SHARES+s)*8 +: 8] = RandxDI[(l*(SHARES-1)+s-1)*8 +: 8];
          w_acc = w_acc ^ RandxDI[(l*(SHARES-1)+s-1)*8 +: 8];
        end
        _XxDO[l*SHARES*8 +: 8] = w_acc;
      end
    end
  end

  // Recombine the output shares of each lane
  always_comb begin
    w_res  = '0;
    w_racc = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      w_racc = '0;
      for (int s = 0; s < int'(SHARES); s++) begin
        w_racc = w_racc ^ _QxDI[(l*SHARES+s)*8 +: 8];
      end
      w_res[l*8 +: 8] = w_racc;
    end
  end

  // Valid/index delay line matching the S-box latency
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        r_vld[i] <= 1'b0;
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_issue;
      r_idx[0] <= w_issue ? r_cur : 8'h00;
      for (int i = 1; i < int'(LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  // In-flight counter and FIFO pointers/occupancy
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= r_inflight + CntW'(w_issue) - CntW'(w_emerge);
      r_count    <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
    end
  end

  // FIFO storage; contents are masked at the output while empty, so no reset needed
  always_ff @(posedge ClkxCI) begin
    if (w_push) r_mem[r_wptr] <= {r_idx[LATENCY-1], w_res};
  end

  assign ResValidxSO      = (r_count != '0);
  assign {IdxxDO, ResxDO} = ResValidxSO ? r_mem[r_rptr] : '0;

endmodule

// File: doc/sbox_share_seq.md
SBOX_SHARE_SEQ -- requirements
Module: sbox_share_seq

Interface
REQ-001 Parameters SHALL be:
- SHARES, default 2: masking order + 1, valid range 2..4.
- LANES, default 1: parallel S-box lanes, valid range 1..4.
- LATENCY, default 4: S-box input-to-output cycles; use 8 for eight-staged S-boxes.
- FIFO_DEPTH, default 8: depth of the result buffer; must be >= LATENCY+1.
REQ-002 Ports, with clock and reset first:
- ClkxCI  in  1  sole clock.
- RstxBI  in  1  reset; asynchronous, active-low.
- StartxSI  in  1  start pulse.
- BasexDI  in  8  first unmasked byte.
- BeatsxDI  in  9  number of issue beats, 1..256.
- RandxDI  in  8*(SHARES-1)*LANES  fresh mask bits.
- RandValidxSI  in  1  RandxDI is fresh this cycle.
- _XxDO  out  8*SHARES*LANES  shared S-box inputs; share s of lane l is at bits [(l*SHARES+s)*8 +: 8].
- _QxDI  in  8*SHARES*LANES  shared S-box outputs, same packing.
- ResxDO  out  8*LANES  recombined results.
- IdxxDO  out  8  unmasked input byte of lane 0.
- ResValidxSO  out  1  result valid.
- ResReadyxSI  in  1  result accepted.
- BusyxSO  out  1  run in progress.
- DonexSO  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
- IDLE goes to RUN when StartxSI=1. Base and beats are latched, and the remaining-beat counter is set to BeatsxDI.
- RUN goes to DRAIN when the remaining-beat count reaches 0.
- DRAIN goes to DONE when the in-flight count is 0 and the FIFO is empty.
- DONE goes to IDLE after one cycle.
REQ-004 StartxSI SHALL be ignored outside IDLE. BeatsxDI=0 SHALL be treated as 256.
REQ-005 An issue SHALL occur in a cycle only when all of the following hold:
- state is RUN;
- remaining beats > 0;
- RandValidxSI=1;
- in-flight count + FIFO occupancy < FIFO_DEPTH.
REQ-006 On an issue, lane l SHALL carry the byte x = (cur+l) mod 256.
- Shares 1..SHARES-1 are the corresponding RandxDI bytes.
- Share 0 is x XOR all other shares.
- cur then advances by LANES mod 256 (wraps 0xFF to 0x00).
REQ-007 In non-issue cycles _XxDO SHALL be all-zero, and no token SHALL be tracked for that cycle.
REQ-008 A valid/index delay line exactly LATENCY deep SHALL accompany each issue. When a token emerges, the XOR of all shares of each lane of _QxDI in that cycle SHALL be written to the FIFO together with its index.
REQ-009 The in-flight count SHALL increment on issue and decrement on emergence. On simultaneous issue and emergence it SHALL be unchanged.
REQ-010 The FIFO SHALL be first-word-fall-through.
- ResValidxSO=1 whenever the FIFO is non-empty.
- An entry pops when ResValidxSO and ResReadyxSI are both 1.
- A push and a pop in the same cycle are both performed, including when the FIFO is full.
- A push to a full FIFO without a pop cannot occur, by REQ-005.
REQ-011 Results SHALL leave in issue order, with no loss or duplication under any ResReadyxSI pattern.
REQ-012 Minimum issue-to-result latency SHALL be LATENCY+1 cycles: one cycle for the FIFO write, with the result visible in the following cycle.
REQ-013 BusyxSO SHALL be 1 in RUN and DRAIN. DonexSO SHALL be 1 only in DONE.
REQ-014 Unmasked data SHALL NOT be registered anywhere except cur and the index pipeline. Share 0 SHALL be computed combinationally from cur and RandxDI.

Reset
REQ-015 When RstxBI=0 the block SHALL immediately return to the reset state, including mid-run:
- state IDLE;
- all counters, the delay line and the FIFO pointers cleared;
- _XxDO, ResxDO and IdxxDO are 0;
- ResValidxSO, BusyxSO and DonexSO are 0.
REQ-016 After reset is released, the first issue SHALL be possible no earlier than the first cycle following a StartxSI pulse.

Verification
REQ-017 The bench SHALL cover the following scenarios, all using a behavioural S-box model with LATENCY delay:
- Sweep: SHARES=2, LANES=1, Base=0x00, Beats=256, RandValid=1, Ready=1.
  - Results are 0x63, 0x7C, 0x77, … in order, with Idx 0..255.
  - First result appears 5 cycles after the first issue.
  - DonexSO pulses once.
- Wrap with lanes: LANES=2, Base=0xFE, Beats=2.
  - Beat 0: Idx=0xFE, Res={0x16 (lane 1), 0xBB (lane 0)}.
  - Beat 1: Idx=0x00, Res={0x7C (lane 1), 0x63 (lane 0)}.
- Backpressure: ResReadyxSI=0 for 30 cycles during a 64-beat run with FIFO_DEPTH=8.
  - Occupancy + in-flight never exceeds 8.
  - After Ready returns, all 64 results arrive in order.
- Randomness stall: RandValidxSI toggled 1/0 each cycle.
  - Issues occur only in RandValid cycles.
  - _XxDO is zero in stalled cycles.
  - Results are unchanged.
- Mask check: SHARES=3 and random RandxDI.
  - XOR of the _XxDO shares equals Idx.
  - Share 1 and share 2 equal the RandxDI bytes.
- Reset mid-run: RstxBI=0 for 1 cycle at beat 20 of 100.
  - All outputs become 0 immediately.
  - A subsequent Start with Base=0x10, Beats=4 yields Idx 0x10..0x13 only.
